// File: rtl/is_pkg_uart_controller.sv
// Shared types for the UART receiver: parity modes, RX FSM states and err_o bit positions.
package is_pkg_uart_controller;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
    } rx_state_e;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;

    // Unknown mode codes behave like NONE so a bad setting never stalls a frame.
    function automatic logic par_enabled(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    function automatic logic par_expected(input logic [2:0] mode, input logic data_xor);
        logic p;
        case (mode)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/is_uart_rx_sampler.sv
// Line synchroniser, per-bit oversample tick counter and bit sampler for the UART receiver.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module is_uart_rx_sampler #(
    parameter int OS_RATE = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic os_ce_i,
    input  logic rxd_i,
    input  logic run_i,
    output logic fall_o,
    output logic bit_o,
    output logic bit_stb_o
);
    localparam int CNT_W = $clog2(OS_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_RATE - 1);
    // cnt_q holds the ticks already seen in this bit, so tick k arrives while cnt_q == k-1.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS_RATE / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(OS_RATE / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(OS_RATE / 2);
    logic [1:0] vote_q;
`endif

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             bit_q;
    logic             stb_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            bit_q   <= 1'b1;
            stb_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef UART_RX_MAJORITY_EN
            vote_q  <= 2'b11;
`endif
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stb_q   <= 1'b0;
            if (!run_i) begin
                cnt_q <= '0;
            end else if (os_ce_i) begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
`ifdef UART_RX_MAJORITY_EN
                if (cnt_q == CNT_EARLY) vote_q[0] <= sync2_q;
                if (cnt_q == CNT_MID)   vote_q[1] <= sync2_q;
                if (cnt_q == CNT_LATE) begin
                    bit_q <= (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) |
                             (vote_q[1] & sync2_q);
                    stb_q <= 1'b1;
                end
`else
                if (cnt_q == CNT_MID) begin
                    bit_q <= sync2_q;
                    stb_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign fall_o    = prev_q & ~sync2_q;
    assign bit_o     = bit_q;
    assign bit_stb_o = stb_q;

endmodule

// File: rtl/is_uart_rx_param.sv
// Oversampling UART receiver with parity, 1/2 stop bits, break detect and a valid/ready output.
// Bit sampling mode is selected by UART_RX_MAJORITY_EN (see is_uart_rx_sampler).
module is_uart_rx_param
    import is_pkg_uart_controller::*;
#(
    parameter int DATA_W  = 8,
    parameter int OS_RATE = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              os_ce_i,
    input  logic              rxd_i,
    input  logic [2:0]        cfg_parity_i,
    input  logic              cfg_stop2_i,
    input  logic              rx_ready_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [2:0]        err_o,
    output logic              rx_break_o,
    output logic              rx_busy_o
);
    localparam int BCNT_W = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    // Output handshake: a word is held on rx_data_o/err_o while rx_valid_o is 1 and is
    // consumed on the clock where rx_valid_o and rx_ready_i are both 1.
    rx_state_e         state_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        err_q;
    logic [2:0]        par_mode_q;
    logic              stop2_q;
    logic              par_err_q;
    logic              par_one_q;
    logic              frame_err_q;
    logic              valid_q;
    logic              break_q;

    logic run;
    logic fall;
    logic samp_bit;
    logic samp_stb;
    logic brk_now;
    logic deliver;
    logic frame_now;

    assign run = (state_q != ST_IDLE);

    is_uart_rx_sampler #(.OS_RATE(OS_RATE)) u_sampler (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .os_ce_i   (os_ce_i),
        .rxd_i     (rxd_i),
        .run_i     (run),
        .fall_o    (fall),
        .bit_o     (samp_bit),
        .bit_stb_o (samp_stb)
    );

    always_comb begin
        brk_now   = ~samp_bit & (shift_q == '0) & ~par_one_q;
        deliver   = 1'b0;
        frame_now = ~samp_bit;
        if (samp_stb) begin
            if (state_q == ST_STOP1) deliver = ~brk_now & ~stop2_q;
            if (state_q == ST_STOP2) deliver = 1'b1;
        end
        if (state_q == ST_STOP2) frame_now = frame_err_q | ~samp_bit;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            err_q       <= '0;
            par_mode_q  <= PAR_NONE;
            stop2_q     <= 1'b0;
            par_err_q   <= 1'b0;
            par_one_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q     <= ST_START;
                        par_mode_q  <= cfg_parity_i;
                        stop2_q     <= cfg_stop2_i;
                        bit_cnt_q   <= '0;
                        par_err_q   <= 1'b0;
                        par_one_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (samp_stb) state_q <= samp_bit ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (samp_stb) begin
                        shift_q <= {samp_bit, shift_q[DATA_W-1:1]};
                        if (bit_cnt_q == BCNT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_enabled(par_mode_q) ? ST_PARITY : ST_STOP1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp_stb) begin
                        par_one_q <= samp_bit;
                        par_err_q <= samp_bit ^ par_expected(par_mode_q, ^shift_q);
                        state_q   <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (samp_stb) begin
                        if (brk_now) begin
                            state_q <= ST_BREAK;
                            break_q <= 1'b1;
                        end else if (stop2_q) begin
                            frame_err_q <= ~samp_bit;
                            state_q     <= ST_STOP2;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (samp_stb) state_q <= ST_IDLE;
                end
                ST_BREAK: begin
                    if (samp_stb && samp_bit) begin
                        break_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A completing frame always wins; overrun flags an unconsumed previous word.
            if (deliver) begin
                data_q              <= shift_q;
                err_q[ERR_OVERRUN]  <= valid_q & ~rx_ready_i;
                err_q[ERR_PARITY]   <= par_err_q;
                err_q[ERR_FRAME]    <= frame_now;
                valid_q             <= 1'b1;
            end else if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;
    assign err_o      = err_q;
    assign rx_break_o = break_q;
    assign rx_busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_is_uart_rx_param.sv
// Self-checking bench for is_uart_rx_param: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_is_uart_rx_param;
    import is_pkg_uart_controller::*;

    localparam int DATA_W  = 8;
    localparam int OS_RATE = 16;

    logic       clk_i;
    logic       rstn_i;
    logic       os_ce_i;
    logic       rxd_i;
    logic [2:0] cfg_parity_i;
    logic       cfg_stop2_i;
    logic       rx_ready_i;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic [2:0] err_o;
    logic       rx_break_o;
    logic       rx_busy_o;

    int  checks   = 0;
    int  failures = 0;
    bit  ce_en    = 1'b1;
    bit  ce_div   = 1'b0;
    bit  word_pending = 1'b0;
    logic [11:0] exp_q[$];

    is_uart_rx_param #(.DATA_W(DATA_W), .OS_RATE(OS_RATE)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .os_ce_i      (os_ce_i),
        .rxd_i        (rxd_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_stop2_i  (cfg_stop2_i),
        .rx_ready_i   (rx_ready_i),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .err_o        (err_o),
        .rx_break_o   (rx_break_o),
        .rx_busy_o    (rx_busy_o)
    );

    // ---------------- clock / reset / tick generation ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        os_ce_i = 1'b0;
        forever begin
            @(negedge clk_i);
            ce_div  = ~ce_div;
            os_ce_i = ce_en && ce_div;
        end
    end

    // ---------------- reference model ----------------
    // Returns {break, overrun, parity_err, frame_err, data} for one frame on the line.
    function automatic logic [11:0] model(input logic [7:0] d, input logic [2:0] mode,
                                          input logic pbit, input logic s1, input logic s2en,
                                          input logic s2, input bit pending);
        bit has_par;
        bit exp_p;
        bit ones_odd;
        bit perr;
        bit ferr;
        bit brk;
        ones_odd = ($countones(d) % 2) == 1;
        has_par  = (mode == PAR_EVEN) || (mode == PAR_ODD) || (mode == PAR_MARK) ||
                   (mode == PAR_SPACE);
        case (mode)
            PAR_EVEN: exp_p = ones_odd;
            PAR_ODD:  exp_p = !ones_odd;
            PAR_MARK: exp_p = 1'b1;
            default:  exp_p = 1'b0;
        endcase
        perr = has_par && (pbit != exp_p);
        ferr = !s1 || (s2en && !s2);
        brk  = (d == 8'h00) && (!has_par || !pbit) && !s1;
        return {brk, pending, perr, ferr, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk_i);
            n++;
        end while (os_ce_i !== 1'b1 && n < 64);
        if (os_ce_i !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout os_ce=%b expected=1", os_ce_i);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd_i = b;
        repeat (OS_RATE) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [2:0] mode, input logic pbit,
                              input logic s1, input logic s2en, input logic s2, input bit disturb);
        cfg_parity_i = mode;
        cfg_stop2_i  = s2en;
        send_bit(1'b0);
        if (disturb) begin
            cfg_parity_i = (mode == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
            cfg_stop2_i  = !s2en;
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (disturb && i == 3) begin
                ce_en = 1'b0;
                repeat (80) @(posedge clk_i);
                #1;
                checks++;
                if ({rx_busy_o, rx_valid_o} !== 2'b10) begin
                    failures++;
                    $display("FAIL freeze busy,valid=%b expected=10", {rx_busy_o, rx_valid_o});
                end
                ce_en = 1'b1;
            end
        end
        if (mode != PAR_NONE) send_bit(pbit);
        send_bit(s1);
        if (s2en) send_bit(s2);
        rxd_i = 1'b1;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk_i);
            if (rx_valid_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        @(posedge clk_i);
        #1;
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_ready_i   = 1'b0;
        word_pending = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn_i       = 1'b0;
        rxd_i        = 1'b1;
        rx_ready_i   = 1'b0;
        cfg_parity_i = PAR_NONE;
        cfg_stop2_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({rx_valid_o, rx_data_o, err_o, rx_break_o, rx_busy_o} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b data=%h err=%b brk=%b busy=%b expected all 0",
                     rx_valid_o, rx_data_o, err_o, rx_break_o, rx_busy_o);
        end
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++;
        if ({rx_valid_o, rx_busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset valid,busy=%b expected=00", {rx_valid_o, rx_busy_o});
        end
    endtask

    task automatic test_parity();
        logic [7:0]  td[5] = '{8'hA5, 8'h01, 8'h01, 8'h3C, 8'h7E};
        logic [2:0]  tm[5] = '{PAR_EVEN, PAR_ODD, PAR_ODD, PAR_MARK, PAR_SPACE};
        logic        tp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] exp;
        bit          got;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model(td[i], tm[i], tp[i], 1'b1, 1'b0, 1'b1, word_pending));
            send_frame(td[i], tm[i], tp[i], 1'b1, 1'b0, 1'b1, 1'b0);
            wait_valid(got);
            exp = exp_q.pop_front();
            checks++;
            if ({got, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
                failures++;
                $display("FAIL parity_%0d valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                         i, got, rx_data_o, err_o, exp[7:0], exp[10:8]);
            end
            accept();
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        rxd_i = 1'b0;
        repeat (3) wait_tick();
        rxd_i = 1'b1;
        checks++;
        if (rx_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start busy=%b expected=1", rx_busy_o);
        end
        for (int i = 0; i < 2 * OS_RATE; i++) begin
            wait_tick();
            if (rx_valid_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if ({seen, rx_busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL glitch_reject valid_seen=%b busy=%b expected 0 0", seen, rx_busy_o);
        end
    endtask

    task automatic test_overrun();
        logic [11:0] exp;
        bit          got;
        logic [7:0]  td[2] = '{8'h11, 8'h22};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(td[i], PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, word_pending));
            send_frame(td[i], PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            wait_valid(got);
            word_pending = 1'b1;
            exp = exp_q.pop_front();
            checks++;
            if ({got, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
                failures++;
                $display("FAIL overrun_%0d valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                         i, got, rx_data_o, err_o, exp[7:0], exp[10:8]);
            end
        end
        accept();
        checks++;
        if (rx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL handshake_clear valid=%b expected=0", rx_valid_o);
        end
    endtask

    task automatic test_stop2();
        logic [7:0]  td[3]  = '{8'h96, 8'h96, 8'h3C};
        logic        ts1[3] = '{1'b1, 1'b0, 1'b1};
        logic        ts2[3] = '{1'b0, 1'b1, 1'b1};
        logic [11:0] exp;
        bit          got;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(td[i], PAR_NONE, 1'b0, ts1[i], 1'b1, ts2[i], word_pending));
            send_frame(td[i], PAR_NONE, 1'b0, ts1[i], 1'b1, ts2[i], 1'b0);
            wait_valid(got);
            exp = exp_q.pop_front();
            checks++;
            if ({got, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
                failures++;
                $display("FAIL stop2_%0d valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                         i, got, rx_data_o, err_o, exp[7:0], exp[10:8]);
            end
            accept();
        end
        cfg_stop2_i = 1'b0;
    endtask

    task automatic test_break();
        logic [11:0] exp;
        cfg_parity_i = PAR_NONE;
        cfg_stop2_i  = 1'b0;
        exp = model(8'h00, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) send_bit(1'b0);
        checks++;
        if ({rx_break_o, rx_busy_o, rx_valid_o} !== {exp[11], 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL break_hold brk=%b busy=%b valid=%b expected %b 1 0",
                     rx_break_o, rx_busy_o, rx_valid_o, exp[11]);
        end
        repeat (2) send_bit(1'b1);
        checks++;
        if ({rx_break_o, rx_busy_o, rx_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL break_release brk=%b busy=%b valid=%b expected 0 0 0",
                     rx_break_o, rx_busy_o, rx_valid_o);
        end
    endtask

    task automatic test_freeze_cfg();
        logic [11:0] exp;
        exp_q.push_back(model(8'hC3, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, word_pending));
        send_frame(8'hC3, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk_i);
        exp = exp_q.pop_front();
        checks++;
        if ({rx_valid_o, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
            failures++;
            $display("FAIL cfg_latch valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                     rx_valid_o, rx_data_o, err_o, exp[7:0], exp[10:8]);
        end
        accept();
        cfg_parity_i = PAR_NONE;
        cfg_stop2_i  = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] exp;
        bit          got;
        cfg_parity_i = PAR_NONE;
        cfg_stop2_i  = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (rx_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy busy=%b expected=1", rx_busy_o);
        end
        rxd_i  = 1'b1;
        rstn_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({rx_valid_o, rx_data_o, err_o, rx_break_o, rx_busy_o} !== 14'h0) begin
            failures++;
            $display("FAIL mid_reset valid=%b data=%h err=%b brk=%b busy=%b expected all 0",
                     rx_valid_o, rx_data_o, err_o, rx_break_o, rx_busy_o);
        end
        @(posedge clk_i);
        #1;
        rstn_i       = 1'b1;
        word_pending = 1'b0;
        repeat (2) send_bit(1'b1);
        exp_q.push_back(model(8'h5A, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, word_pending));
        send_frame(8'h5A, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_valid(got);
        exp = exp_q.pop_front();
        checks++;
        if ({got, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
            failures++;
            $display("FAIL after_reset valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                     got, rx_data_o, err_o, exp[7:0], exp[10:8]);
        end
        accept();
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [2:0]  mode;
        logic        pbit;
        logic        s1;
        logic        s2en;
        logic        s2;
        logic [11:0] exp;
        bit          got;
        for (int i = 0; i < 20; i++) begin
            d    = 8'($urandom_range(0, 255));
            mode = 3'($urandom_range(0, 4));
            pbit = 1'($urandom_range(0, 1));
            s1   = ($urandom_range(0, 7) != 0);
            s2en = 1'($urandom_range(0, 1));
            s2   = ($urandom_range(0, 7) != 0);
            exp  = model(d, mode, pbit, s1, s2en, s2, word_pending);
            if (exp[11]) begin
                s1  = 1'b1;
                exp = model(d, mode, pbit, s1, s2en, s2, word_pending);
            end
            exp_q.push_back(exp);
            send_frame(d, mode, pbit, s1, s2en, s2, 1'b0);
            wait_valid(got);
            exp = exp_q.pop_front();
            checks++;
            if ({got, rx_data_o, err_o} !== {1'b1, exp[7:0], exp[10:8]}) begin
                failures++;
                $display("FAIL random_%0d mode=%0d valid=%b data=%h err=%b expected valid=1 data=%h err=%b",
                         i, mode, got, rx_data_o, err_o, exp[7:0], exp[10:8]);
            end
            accept();
            send_bit(1'b1);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_parity();
        test_glitch();
        test_overrun();
        test_stop2();
        test_break();
        test_freeze_cfg();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
